// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display path.
// Also used by the scan driver for its blank/default digit code.
package seg_pkg;

  localparam int DIG_W = 8;
  localparam int NDIG  = 6;

  localparam logic [7:0]  BLANK_CODE = 8'hFF;
  localparam logic [7:0]  ERR_CODE   = 8'h0E;
  localparam logic [23:0] DEC_MAX    = 24'd999999;

  typedef logic [DIG_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_t;

endpackage

// File: rtl/seg_digit_encoder_if.sv
// Request/result bundle between the display register and the encoder.
// The encoder results feed the scan driver digit inputs.
interface seg_digit_encoder_if;
  import seg_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [23:0] value;
  logic        hex_mode;
  logic        blank_lz;
  logic        out_valid;
  code_t       data0;
  code_t       data1;
  code_t       data2;
  code_t       data3;
  code_t       data4;
  code_t       data5;

  modport master (
    output in_valid,
    output value,
    output hex_mode,
    output blank_lz,
    input  in_ready,
    input  out_valid,
    input  data0,
    input  data1,
    input  data2,
    input  data3,
    input  data4,
    input  data5
  );

  modport slave (
    input  in_valid,
    input  value,
    input  hex_mode,
    input  blank_lz,
    output in_ready,
    output out_valid,
    output data0,
    output data1,
    output data2,
    output data3,
    output data4,
    output data5
  );

endinterface

// File: rtl/dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5,
// then shift the BCD register left, pulling in the binary MSB.
module dd_step (
  input  logic [23:0] bcd,
  input  logic        msb,
  output logic [23:0] nxt
);

  logic [23:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  assign nxt = {adj[22:0], msb};

endmodule

// File: rtl/seg_digit_encoder.sv
// Binary to six digit codes, hex or decimal (iterative double-dabble),
// with optional leading-zero blanking. Digits held until next result.
module seg_digit_encoder
  import seg_pkg::*;
#(
  parameter int DEC_BITS = 20
) (
  input logic               clk,
  input logic               rst_n,
  seg_digit_encoder_if.slave bus
);

  localparam int CW = $clog2(DEC_BITS);

  state_t              state;
  state_t              state_nxt;
  logic [23:0]         val_q;
  logic                hex_q;
  logic                blank_q;
  logic [CW-1:0]       cnt;
  logic [23:0]         bcd;
  logic [23:0]         bcd_nxt;
  logic [DEC_BITS-1:0] bin;
  code_t [NDIG-1:0]    dig_q;
  code_t [NDIG-1:0]    dig_d;
  logic                out_valid_q;
  logic                accept;
  logic                ovf_in;
  logic                ovf_q;
  logic                seen;
  logic [3:0]          nib;

  assign accept = bus.in_valid && (state == IDLE);
  assign ovf_in = !bus.hex_mode && (bus.value > DEC_MAX);

  dd_step u_dd (
    .bcd (bcd),
    .msb (bin[DEC_BITS-1]),
    .nxt (bcd_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = (bus.hex_mode || ovf_in) ? FINISH : CONV;
      end
      CONV: begin
        if (cnt == '0)
          state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Digit selection and blanking from the latched request
  always_comb begin
    ovf_q = !hex_q && (val_q > DEC_MAX);
    seen  = 1'b0;
    dig_d = '0;
    nib   = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nib  = hex_q ? val_q[4*i +: 4] : bcd[4*i +: 4];
      seen = seen | (nib != 4'h0);
      if (blank_q && !seen && (i != 0))
        dig_d[i] = BLANK_CODE;
      else
        dig_d[i] = {4'h0, nib};
    end
    if (ovf_q) begin
      for (int i = 0; i < NDIG - 1; i++)
        dig_d[i] = BLANK_CODE;
      dig_d[NDIG-1] = ERR_CODE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q       <= '0;
      hex_q       <= 1'b0;
      blank_q     <= 1'b0;
      cnt         <= '0;
      bcd         <= '0;
      bin         <= '0;
      dig_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state == FINISH);
      unique case (state)
        IDLE: begin
          if (accept) begin
            val_q   <= bus.value;
            hex_q   <= bus.hex_mode;
            blank_q <= bus.blank_lz;
            cnt     <= CW'(DEC_BITS - 1);
            bcd     <= '0;
            bin     <= bus.value[DEC_BITS-1:0];
          end
        end
        CONV: begin
          bcd <= bcd_nxt;
          bin <= {bin[DEC_BITS-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        FINISH:  dig_q <= dig_d;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.data0     = dig_q[0];
  assign bus.data1     = dig_q[1];
  assign bus.data2     = dig_q[2];
  assign bus.data3     = dig_q[3];
  assign bus.data4     = dig_q[4];
  assign bus.data5     = dig_q[5];

endmodule

// File: tb/tb_seg_digit_encoder.sv
// Scoreboard bench for seg_digit_encoder: directed requests,
// expected digits queued at issue, checked on each out_valid.
module tb_seg_digit_encoder;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  logic [47:0] exp_q[$];

  seg_digit_encoder_if bus ();

  seg_digit_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  wire [47:0] act = {bus.data5, bus.data4, bus.data3,
                     bus.data2, bus.data1, bus.data0};

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a === e)
      passed++;
    else
      $display("FAIL %s got=%0h required=%0h", nm, a, e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out got=%0h required=none", act);
      end else begin
        chk("data", act, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [23:0] v,
                       input logic        hx,
                       input logic        bl,
                       input logic [47:0] e,
                       input int          lat);
    int n;
    int low;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1);
    bus.value    = v;
    bus.hex_mode = hx;
    bus.blank_lz = bl;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n   = 0;
    low = 0;
    while (!bus.out_valid && n < 40) begin
      if (!bus.in_ready) low++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, lat);
    chk("ready_low", low, lat);
    chk("ready_back", bus.in_ready, 1);
    @(posedge clk);
    #1 chk("pulse_end", bus.out_valid, 0);
  endtask

  initial begin
    int acc_k;
    passed       = 0;
    total        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.value    = '0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    #5;
    chk("rst_data", act, 48'h0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    issue(24'd123456, 0, 0, 48'h01_02_03_04_05_06, 21);
    issue(24'd42,     0, 1, 48'hFF_FF_FF_FF_04_02, 21);
    issue(24'd0,      0, 1, 48'hFF_FF_FF_FF_FF_00, 21);
    issue(24'hABCDEF, 1, 0, 48'h0A_0B_0C_0D_0E_0F, 1);
    issue(24'h00F000, 1, 1, 48'hFF_FF_0F_00_00_00, 1);
    issue(24'd1000000, 0, 0, 48'h0E_FF_FF_FF_FF_FF, 1);
    issue(24'd999999, 0, 0, 48'h09_09_09_09_09_09, 21);
    issue(24'hFFFFFF, 0, 1, 48'h0E_FF_FF_FF_FF_FF, 1);
    issue(24'h000000, 1, 1, 48'hFF_FF_FF_FF_FF_00, 1);
    issue(24'd100000, 0, 1, 48'h01_00_00_00_00_00, 21);

    // Request held with changing inputs while busy
    @(negedge clk);
    bus.value    = 24'd123456;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    bus.in_valid = 1'b1;
    exp_q.push_back(48'h01_02_03_04_05_06);
    @(posedge clk);
    acc_k = 0;
    for (int k = 1; k <= 40 && acc_k == 0; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        bus.value    = 24'd654321;
        bus.hex_mode = 1'b0;
        bus.blank_lz = 1'b1;
        exp_q.push_back(48'h06_05_04_03_02_01);
        acc_k = k;
      end else begin
        bus.value    = 24'(k * 37);
        bus.hex_mode = k[0];
        bus.blank_lz = k[1];
      end
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
    chk("accept_edge", acc_k, 22);
    for (int n = 0; n < 50 && exp_q.size() != 0; n++)
      @(posedge clk);
    @(posedge clk);
    chk("drain", exp_q.size(), 0);

    // Reset mid-conversion
    @(negedge clk);
    bus.value    = 24'd777777;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", act, 48'h0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    issue(24'd305, 0, 1, 48'hFF_FF_FF_03_00_05, 21);
    repeat (25) @(posedge clk);
    chk("final_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_digit_encoder.md
# seg_digit_encoder

Converts a binary value into the six per-digit codes consumed by the six-digit seven-segment scan driver (its `data0`..`data5` inputs). The value is shown as hexadecimal or as decimal, with optional leading-zero blanking. The block sits between the CPU's memory-mapped display register and the scan driver. Decimal conversion is an iterative 20-step double-dabble; output digits are registered and held until the next conversion completes.

## Interface
- `DEC_BITS`, 20: binary width shifted in decimal mode (999999 < 2^20)
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  reset; asynchronous, active-low
- `in_valid`  in  1  request a conversion of `value`
- `in_ready`  out  1  block idle; a request is accepted when `in_valid && in_ready`
- `value`  in  24  binary value to display
- `hex_mode`  in  1  1 = six hex digits, 0 = decimal; sampled at accept
- `blank_lz`  in  1  1 = blank leading zeros; sampled at accept
- `out_valid`  out  1  one-cycle pulse when `data0`..`data5` take new values
- `data0`..`data5`  out  8 each  digit codes; `data0` is the least significant digit. Codes: 0x00–0x0F = digit, 0xFF = blank (driver shows all segments off)

## Operation
- FSM states: IDLE, CONV, FINISH.
- IDLE: `in_ready`=1. On accept, latch `value`, `hex_mode` and `blank_lz`.
  - Hex mode, or decimal with `value` > 999999: go to FINISH.
  - Otherwise go to CONV with iteration count 19, BCD register 0, and shift register = `value[19:0]`.
- CONV: each cycle, apply add-3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. After the iteration where the count is 0, go to FINISH.
- FINISH: compute six nibbles.
  - Hex mode: nibble i = `value[4i+3:4i]`.
  - Decimal overflow: `data0`..`data4` = 0xFF and `data5` = 0x0E (shows "E").
  - Decimal normal: nibble i = BCD digit i.
  - If `blank_lz`: every digit above the most significant non-zero digit becomes 0xFF. `data0` is never blanked, so value 0 shows "0".
  - Register the outputs, pulse `out_valid`, return to IDLE.
- `in_valid` while busy (`in_ready`=0) is ignored. No queuing; the upstream holds the request.
- Outputs are stable between `out_valid` pulses.
- Reset (asynchronous, any state, including mid-CONV) sets:
  - state = IDLE, `in_ready`=1, `out_valid`=0
  - `data0`..`data5` = 0x00
  - internal shift/BCD registers cleared
  - any in-progress conversion is discarded.

## Timing
- Accept at edge E0.
- Hex or overflow: FINISH during the cycle after E0. Outputs update and `out_valid`=1 after E1. `in_ready`=1 again after E1.
- Decimal: CONV covers edges E1..E20. FINISH runs in the cycle after E20. Outputs update and `out_valid`=1 after E21. `in_ready` is low from after E0 until after E21.
- Back-to-back requests: the next accept can occur at E2 (hex) or E22 (decimal).
- `out_valid` is high for exactly one cycle per accepted request.
- The downstream scan driver samples only at its 1 kHz scan tick, so mid-conversion values are never exposed: outputs change only in FINISH.

## Structure
- Shared package `seg_pkg` holds:
  - `BLANK_CODE`=8'hFF, `ERR_CODE`=8'h0E, `DEC_MAX`=24'd999999
  - state enum {IDLE, CONV, FINISH}
  - digit-code width 8
- The scan driver uses the same package for its blank/default code.
- One sub-module: `dd_step`, combinational. Input is the 24-bit BCD register plus the bin MSB; output is the corrected and shifted BCD value. Instantiated once and used in CONV.

## Test plan
- Decimal, `value`=123456, `blank_lz`=0 → after E21, `data5`..`data0` = 1,2,3,4,5,6; `out_valid` high for 1 cycle; `in_ready` low for 21 cycles.
- Decimal, `value`=42, `blank_lz`=1 → `data0`=2, `data1`=4, `data2`..`data5`=0xFF. Then `value`=0, `blank_lz`=1 → `data0`=0, all others 0xFF.
- Hex, `value`=24'hABCDEF → after E1, `data5`..`data0` = 0x0A,0x0B,0x0C,0x0D,0x0E,0x0F. Hex, `value`=24'h00F000, `blank_lz`=1 → `data3`=0x0F, `data2`..`data0`=0, `data5`/`data4`=0xFF.
- Decimal, `value`=1000000 → after E1, `data5`=0x0E and others 0xFF. Decimal, `value`=999999 → all digits 9 after E21.
- Hold `in_valid`=1 with changing `value` during CONV → the changes are ignored, and the result matches the value latched at accept. The second request is accepted at E22 exactly.
- Assert `rst_n`=0 at E10 of a decimal conversion → outputs immediately 0x00, `out_valid`=0, `in_ready`=1. After release, a new request converts correctly with no leftover state.
